// File: rtl/i2s_master_rx_clken.sv
// I2S master receiver: generates BCLK/LRCLK, deserialises L/R samples and issues
// 48 kHz / 192 kHz clock-enable strobes locked to the same divider chain.
module i2s_master_rx_clken #(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned DATA_W    = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              i2s_sdin,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic [DATA_W-1:0] LEFTout,
    output logic [DATA_W-1:0] RIGHTout,
    output logic              clken48kHz,
    output logic              clken192kHz
);
    localparam int unsigned     DivW      = $clog2(BCLK_HALF);
    localparam logic [DivW-1:0] DivLast   = DivW'(BCLK_HALF - 1);
    localparam logic [5:0]      LeftLast  = 6'(DATA_W);
    localparam logic [5:0]      RightLast = 6'(32 + DATA_W);

    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              first_frame_q, first_frame_d;
    logic [1:0]        sync_q, sync_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] left_sh_q, left_sh_d;
    logic [DATA_W-1:0] right_sh_q, right_sh_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              ev48_q, ev48_d;
    logic              ev192_q, ev192_d;
    logic              c48_q, c48_d;
    logic              c192_q, c192_d;

    logic toggle, rise, fall, wrap, data_slot, sdin_s;

    assign sdin_s    = sync_q[1];
    assign toggle    = (div_cnt_q == DivLast);
    assign rise      = toggle & ~bclk_q;
    assign fall      = toggle & bclk_q;
    assign wrap      = fall & (bit_cnt_q == 6'd63);
    // Slots 0 and 32 carry the I2S one-bit delay; everything past DATA_W is pad.
    assign data_slot = ((bit_cnt_q >= 6'd1) && (bit_cnt_q <= LeftLast)) ||
                       ((bit_cnt_q >= 6'd33) && (bit_cnt_q <= RightLast));

    always_comb begin
        div_cnt_d     = div_cnt_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        bit_cnt_d     = bit_cnt_q;
        first_frame_d = first_frame_q;
        sync_d        = {sync_q[0], i2s_sdin};
        shift_d       = shift_q;
        left_sh_d     = left_sh_q;
        right_sh_d    = right_sh_q;
        left_d        = left_q;
        right_d       = right_q;
        ev48_d        = 1'b0;
        ev192_d       = 1'b0;
        c48_d         = ev48_q;
        c192_d        = ev192_q;

        if (!enable) begin
            div_cnt_d     = '0;
            bclk_d        = 1'b0;
            lrclk_d       = 1'b0;
            bit_cnt_d     = 6'd63;
            first_frame_d = 1'b1;
            c48_d         = 1'b0;
            c192_d        = 1'b0;
        end else begin
            div_cnt_d = toggle ? '0 : div_cnt_q + 1'b1;
            if (toggle) begin
                bclk_d = ~bclk_q;
            end
            if (fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                lrclk_d   = bit_cnt_d[5];
                ev192_d   = (bit_cnt_d[3:0] == 4'd0);
            end
            if (rise && data_slot) begin
                shift_d = (shift_q << 1) | DATA_W'(sdin_s);
            end
            if (rise && (bit_cnt_q == LeftLast)) begin
                left_sh_d = shift_d;
            end
            if (rise && (bit_cnt_q == RightLast)) begin
                right_sh_d = shift_d;
            end
            // The first wrap after reset/enable closes a frame that was never captured.
            if (wrap) begin
                if (first_frame_q) begin
                    first_frame_d = 1'b0;
                end else begin
                    left_d  = left_sh_q;
                    right_d = right_sh_q;
                    ev48_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            bit_cnt_q     <= 6'd63;
            first_frame_q <= 1'b1;
            sync_q        <= '0;
            shift_q       <= '0;
            left_sh_q     <= '0;
            right_sh_q    <= '0;
            left_q        <= '0;
            right_q       <= '0;
            ev48_q        <= 1'b0;
            ev192_q       <= 1'b0;
            c48_q         <= 1'b0;
            c192_q        <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            bit_cnt_q     <= bit_cnt_d;
            first_frame_q <= first_frame_d;
            sync_q        <= sync_d;
            shift_q       <= shift_d;
            left_sh_q     <= left_sh_d;
            right_sh_q    <= right_sh_d;
            left_q        <= left_d;
            right_q       <= right_d;
            ev48_q        <= ev48_d;
            ev192_q       <= ev192_d;
            c48_q         <= c48_d;
            c192_q        <= c192_d;
        end
    end

    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign LEFTout     = left_q;
    assign RIGHTout    = right_q;
    assign clken48kHz  = c48_q;
    assign clken192kHz = c192_q;

endmodule
